issue_writeback_ctrl: RTL and testbench
=======================================

// Module: issue_writeback_ctrl
// PURPOSE
//  Drives the execute unit's operand side and consumes its result side. Accepts one instruction
//  word per handshake, decodes it, reads the register file and presents rs1_data/rs2_data/imm/
//  opcode/func to execute_rtl. It then commits sonuc to the register file when we=1, advances
//  or redirects the PC on pc_update, and halts permanently when hata=1.
// PARAMETERS
//  XLEN      32  datapath width
//  NREG      16  register count; r0 reads 0 and ignores writes
//  PC_RESET  0   PC value after reset
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  instr_valid  in   1     instruction word on instr is valid
//  instr        in   32    [6:0] opcode, [10:7] rd, [14:11] rs1, [18:15] rs2, [22:19] func, [31:23] imm9
//  instr_ready  out  1     controller accepts instr this cycle
//  pc           out  XLEN  fetch address of the next instruction
//  rs1_data     out  XLEN  to execute unit
//  rs2_data     out  XLEN  to execute unit
//  imm          out  XLEN  sign-extended imm9, to execute unit
//  opcode       out  7     to execute unit
//  func         out  4     to execute unit
//  sonuc        in   XLEN  execute result
//  we           in   1     execute requests register write
//  pc_update    in   1     execute requests branch redirect
//  hata         in   1     execute error
//  halted       out  1     controller is in HALT
//  retired      out  16    count of committed instructions, wraps at 0xFFFF
// BEHAVIOUR
//  Reset values: state=IDLE, pc=PC_RESET, all registers 0, operand outputs 0, opcode=0,
//    func=0, instr_ready=0, halted=0, retired=0.
//  FSM: IDLE -> ISSUE -> WB -> IDLE; WB -> HALT on hata; HALT exits only through rst.
//  IDLE: instr_ready=1. On instr_valid&instr_ready, register the decoded fields and go to ISSUE.
//    Without instr_valid, stay in IDLE.
//  ISSUE: operand outputs are driven from registers (rs1/rs2 read from the regfile this cycle)
//    and are stable for the whole of ISSUE and WB. instr_ready=0.
//  WB: sample sonuc/we/pc_update/hata.
//    hata=1: no register write, pc unchanged, retired unchanged; next state HALT, halted=1 from
//      the next cycle.
//    Otherwise: if we and rd!=0, write reg[rd] <= sonuc. pc <= pc_update ? pc + (imm<<2) : pc + 4.
//      XLEN modulo arithmetic; wrap-around is legal. retired increments by 1. Next state IDLE.
//  Instruction latency: 3 cycles from accept to the next instr_ready.
//  Regfile reads in ISSUE see the value written in the previous WB; no bypass is needed.
//  rd=0 with we=1: write is dropped, the instruction still retires.
//  HALT: instr_ready=0; operand outputs hold their last values; no state changes.
//  rst asserted mid-instruction: all state returns to reset values immediately; the pending
//    instruction is discarded.
//  Undecoded opcodes are passed through unchanged; execute_rtl flags them through hata.
// STRUCTURE
//  Package cpu_pkg: ctrl_state_t enum (IDLE, ISSUE, WB, HALT), instruction field bit-position
//    localparams, the imm9 sign-extension function, and the PC_STEP=4 constant.
//  Sub-module reg_file_2r1w: NREG x XLEN, two asynchronous read ports, one synchronous write
//    port, r0 hardwired to 0, asynchronous reset clears all entries.
// TESTING
//  1) Reset, then accept instr rd=1 opcode=0000001 func=0000 rs1=0 rs2=0 imm=5 with the stub
//     returning sonuc=9 and we=1 -> reg1=9, pc=4, retired=1, instr_ready high again in cycle 3.
//  2) Load r1=4 and r2=7, issue an instruction reading rs1=1 and rs2=2 -> rs1_data=4 and
//     rs2_data=7 during ISSUE and WB; a stub result of 11 is written to rd.
//  3) pc=8 with imm=-2 and pc_update=1 -> pc=0. pc=0xFFFFFFFC with no branch -> pc wraps to 0.
//  4) hata=1 in WB with we=1 -> no register write, pc held, halted=1, instr_ready stays 0 while
//     instr_valid is held high for 10 cycles.
//  5) we=1 with rd=0 and sonuc=0xDEAD -> r0 still reads 0 and retired increments.
//  6) Assert rst during ISSUE -> pc=PC_RESET, state=IDLE, registers cleared. After release,
//     instr_valid held low -> the controller idles with retired=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and instruction-field layout for the issue/writeback controller.
// The imm9 sign-extender returns 64 bits so callers can size-cast to any XLEN up to 64.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2,
        HALT  = 2'd3
    } ctrl_state_t;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int RD_LSB     = 7;
    localparam int RS1_LSB    = 11;
    localparam int RS2_LSB    = 15;
    localparam int FUNC_LSB   = 19;
    localparam int FUNC_W     = 4;
    localparam int IMM_LSB    = 23;
    localparam int IMM_W      = 9;
    localparam int REG_IDX_W  = 4;

    localparam int PC_STEP = 4;

    function automatic logic [63:0] sext_imm9(input logic [IMM_W-1:0] v);
        return {{(64-IMM_W){v[IMM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// Entry 0 always reads zero and never takes a write.
module reg_file_2r1w
    import cpu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rd_addr1,
    output logic [XLEN-1:0]      rd_data1,
    input  logic [REG_IDX_W-1:0] rd_addr2,
    output logic [XLEN-1:0]      rd_data2,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]      wr_data
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0) && (int'(wr_addr) < NREG)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Out-of-range indices (only possible when NREG < 16) read as zero.
    assign rd_data1 = ((rd_addr1 == '0) || (int'(rd_addr1) >= NREG)) ? '0 : regs[rd_addr1];
    assign rd_data2 = ((rd_addr2 == '0) || (int'(rd_addr2) >= NREG)) ? '0 : regs[rd_addr2];

endmodule

// File: rtl/issue_writeback_ctrl.sv
// Issues one decoded instruction at a time to the execute unit and commits its result.
// state | meaning
// IDLE  | ready for a new instruction word
// ISSUE | operands read from the register file and presented
// WB    | execute result sampled; regfile/pc/retired updated unless hata
// HALT  | execute error seen; frozen until reset
module issue_writeback_ctrl
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 16,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    output logic [XLEN-1:0]     imm,
    output logic [OPCODE_W-1:0] opcode,
    output logic [FUNC_W-1:0]   func,
    input  logic [XLEN-1:0]     sonuc,
    input  logic                we,
    input  logic                pc_update,
    input  logic                hata,
    output logic                halted,
    output logic [15:0]         retired
);

    ctrl_state_t state_q, state_d;

    logic [XLEN-1:0]      pc_q, pc_d;
    logic [REG_IDX_W-1:0] rd_q, rs1_q, rs2_q;
    logic [OPCODE_W-1:0]  opcode_q;
    logic [FUNC_W-1:0]    func_q;
    logic [XLEN-1:0]      imm_q;
    logic [XLEN-1:0]      rs1_hold, rs2_hold;
    logic [15:0]          retired_q;
    logic                 instr_ready_q, halted_q;
    logic                 accept, rf_we, retire;
    logic [XLEN-1:0]      rf_rd1, rf_rd2;

    assign accept = instr_valid && instr_ready_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rf_we   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WB;
            end
            WB: begin
                if (hata) begin
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                    rf_we   = we && (rd_q != '0);
                    retire  = 1'b1;
                    pc_d    = pc_update ? (pc_q + (imm_q << 2)) : (pc_q + XLEN'(PC_STEP));
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET;
            retired_q     <= '0;
            instr_ready_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_ready_q <= (state_d == IDLE);
            halted_q      <= (state_d == HALT);
            if (retire) begin
                retired_q <= retired_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            opcode_q <= '0;
            func_q   <= '0;
            imm_q    <= '0;
            rs1_hold <= '0;
            rs2_hold <= '0;
        end else begin
            if (accept && (state_q == IDLE)) begin
                rd_q     <= instr[RD_LSB +: REG_IDX_W];
                rs1_q    <= instr[RS1_LSB +: REG_IDX_W];
                rs2_q    <= instr[RS2_LSB +: REG_IDX_W];
                opcode_q <= instr[OPCODE_LSB +: OPCODE_W];
                func_q   <= instr[FUNC_LSB +: FUNC_W];
                imm_q    <= XLEN'(sext_imm9(instr[IMM_LSB +: IMM_W]));
            end
            // Operands captured here keep the outputs steady through WB and HALT.
            if (state_q == ISSUE) begin
                rs1_hold <= rf_rd1;
                rs2_hold <= rf_rd2;
            end
        end
    end

    reg_file_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rs1_q),
        .rd_data1 (rf_rd1),
        .rd_addr2 (rs2_q),
        .rd_data2 (rf_rd2),
        .wr_en    (rf_we),
        .wr_addr  (rd_q),
        .wr_data  (sonuc)
    );

    assign rs1_data    = (state_q == ISSUE) ? rf_rd1 : rs1_hold;
    assign rs2_data    = (state_q == ISSUE) ? rf_rd2 : rs2_hold;
    assign imm         = imm_q;
    assign opcode      = opcode_q;
    assign func        = func_q;
    assign pc          = pc_q;
    assign instr_ready = instr_ready_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_issue_writeback_ctrl.sv
// Directed bench for issue_writeback_ctrl; the bench plays the execute unit.
module tb_issue_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [6:0]  opcode;
    logic [3:0]  func;
    logic [31:0] sonuc = '0;
    logic        we = 1'b0;
    logic        pc_update = 1'b0;
    logic        hata = 1'b0;
    logic        halted;
    logic [15:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    issue_writeback_ctrl #(
        .XLEN     (32),
        .NREG     (16),
        .PC_RESET (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .opcode      (opcode),
        .func        (func),
        .sonuc       (sonuc),
        .we          (we),
        .pc_update   (pc_update),
        .hata        (hata),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [3:0] rd,
                                             input logic [3:0] rs1, input logic [3:0] rs2,
                                             input logic [3:0] fn, input logic [8:0] imm9);
        return {imm9, fn, rs2, rs1, rd, op};
    endfunction

    task automatic chk_post(input string tag, input logic [31:0] e_pc, input logic [15:0] e_ret,
                            input logic e_ready, input logic e_halted);
        chk({tag, "_pc"}, pc, e_pc);
        chk({tag, "_retired"}, 32'(retired), 32'(e_ret));
        chk({tag, "_ready"}, 32'(instr_ready), 32'(e_ready));
        chk({tag, "_halted"}, 32'(halted), 32'(e_halted));
    endtask

    // Called at a falling edge; returns at the falling edge after the WB commit edge.
    task automatic do_instr(input string tag, input logic [6:0] op, input logic [3:0] rd,
                            input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] fn,
                            input logic [8:0] imm9, input logic [31:0] res,
                            input logic w, input logic pcu, input logic err,
                            input logic [31:0] e_rs1, input logic [31:0] e_rs2);
        logic [31:0] e_imm;
        int waited;
        e_imm  = {{23{imm9[8]}}, imm9};
        waited = 0;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            chk({tag, "_ready_timeout"}, 32'(instr_ready), 32'd1);
            return;
        end
        instr       = mk_instr(op, rd, rs1, rs2, fn, imm9);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        sonuc       = res;
        we          = w;
        pc_update   = pcu;
        hata        = err;
        chk({tag, "_issue_ready"}, 32'(instr_ready), 32'd0);
        chk({tag, "_issue_rs1"}, rs1_data, e_rs1);
        chk({tag, "_issue_rs2"}, rs2_data, e_rs2);
        chk({tag, "_issue_imm"}, imm, e_imm);
        chk({tag, "_issue_opcode"}, 32'(opcode), 32'(op));
        chk({tag, "_issue_func"}, 32'(func), 32'(fn));
        @(negedge clk);
        chk({tag, "_wb_rs1"}, rs1_data, e_rs1);
        chk({tag, "_wb_rs2"}, rs2_data, e_rs2);
        @(negedge clk);
        sonuc     = '0;
        we        = 1'b0;
        pc_update = 1'b0;
        hata      = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'd1);

        // basic write r1=9; ready back three cycles after accept
        do_instr("t1", 7'd1, 4'd1, 4'd0, 4'd0, 4'd0, 9'd5, 32'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_post("t1", 32'd4, 16'd1, 1'b1, 1'b0);
        do_instr("t1_rd", 7'd2, 4'd0, 4'd1, 4'd0, 4'd3, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd0);
        chk_post("t1_rd", 32'd8, 16'd2, 1'b1, 1'b0);

        // operand read-back after writes
        do_instr("t2_r2", 7'd1, 4'd2, 4'd0, 4'd0, 4'd0, 9'd0, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        do_instr("t2_r1", 7'd1, 4'd1, 4'd0, 4'd0, 4'd0, 9'd0, 32'd4, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        do_instr("t2_add", 7'h33, 4'd3, 4'd1, 4'd2, 4'd0, 9'd0, 32'd11, 1'b1, 1'b0, 1'b0, 32'd4, 32'd7);
        chk_post("t2_add", 32'd20, 16'd5, 1'b1, 1'b0);
        do_instr("t2_rd3", 7'd2, 4'd0, 4'd3, 4'd1, 4'd0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd11, 32'd4);
        chk_post("t2_rd3", 32'd24, 16'd6, 1'b1, 1'b0);

        // branches: 24 -> 8 -> 0 -> 0xFFFFFFFC -> wrap to 0
        do_instr("t3_b1", 7'h63, 4'd0, 4'd0, 4'd0, 4'd0, 9'h1FC, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk_post("t3_b1", 32'd8, 16'd7, 1'b1, 1'b0);
        do_instr("t3_b2", 7'h63, 4'd0, 4'd0, 4'd0, 4'd0, 9'h1FE, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk_post("t3_b2", 32'd0, 16'd8, 1'b1, 1'b0);
        do_instr("t3_b3", 7'h63, 4'd0, 4'd0, 4'd0, 4'd0, 9'h1FF, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        chk_post("t3_b3", 32'hFFFF_FFFC, 16'd9, 1'b1, 1'b0);
        do_instr("t3_wrap", 7'd1, 4'd0, 4'd0, 4'd0, 4'd0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_post("t3_wrap", 32'd0, 16'd10, 1'b1, 1'b0);

        // write to r0 is dropped but retires
        do_instr("t5_r0", 7'd1, 4'd0, 4'd0, 4'd0, 4'd0, 9'd0, 32'hDEAD, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_post("t5_r0", 32'd4, 16'd11, 1'b1, 1'b0);
        do_instr("t5_rd", 7'd2, 4'd0, 4'd0, 4'd3, 4'd0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd11);
        chk_post("t5_rd", 32'd8, 16'd12, 1'b1, 1'b0);

        // execute error -> HALT, ignores further instruction words
        do_instr("t4_err", 7'h7F, 4'd5, 4'd1, 4'd2, 4'd0, 9'd0, 32'h55, 1'b1, 1'b0, 1'b1, 32'd4, 32'd7);
        chk_post("t4_err", 32'd8, 16'd12, 1'b0, 1'b1);
        instr       = mk_instr(7'd1, 4'd6, 4'd0, 4'd0, 4'd0, 9'd1);
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_halt_ready", 32'(instr_ready), 32'd0);
        end
        instr_valid = 1'b0;
        chk_post("t4_halt", 32'd8, 16'd12, 1'b0, 1'b1);
        chk("t4_hold_rs1", rs1_data, 32'd4);
        chk("t4_hold_rs2", rs2_data, 32'd7);

        // reset during ISSUE discards the instruction and clears state
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_instr("t6_w", 7'd1, 4'd1, 4'd0, 4'd0, 4'd0, 9'd0, 32'h77, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_post("t6_w", 32'd4, 16'd1, 1'b1, 1'b0);
        instr       = mk_instr(7'd2, 4'd2, 4'd1, 4'd0, 4'd0, 9'd0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("t6_issue_rs1", rs1_data, 32'h77);
        rst = 1'b1;
        #1;
        chk_post("t6_rst", 32'd0, 16'd0, 1'b0, 1'b0);
        chk("t6_rst_rs1", rs1_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_post("t6_idle", 32'd0, 16'd0, 1'b1, 1'b0);
        do_instr("t6_rd", 7'd2, 4'd0, 4'd1, 4'd0, 4'd0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_post("t6_rd", 32'd4, 16'd1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
